// File: rtl/scv_boot_ctrl_if.sv
// Download path and boot-ROM block RAM port shared by the host loader and the
// boot sequencer. The host/BRAM side is the master and the sequencer is the slave.
interface scv_boot_ctrl_if #(
  parameter int unsigned ROM_AW = 12
);

  // Host download bus
  logic              DL_ACTIVE;
  logic              DL_WR;
  logic [ROM_AW-1:0] DL_ADDR;
  logic [7:0]        DL_DATA;

  // Single-port boot-ROM block RAM
  logic [ROM_AW-1:0] ROM_A;
  logic [7:0]        ROM_D;
  logic              ROM_WE;
  logic [7:0]        ROM_Q;

  modport master (
    output DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA,
    output ROM_Q,
    input  ROM_A, ROM_D, ROM_WE
  );

  modport slave (
    input  DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA,
    input  ROM_Q,
    output ROM_A, ROM_D, ROM_WE
  );

endinterface

// File: rtl/scv_boot_ctrl.sv
// Boot/run sequencer for the uPD7800 core in the Super Cassette Vision top.
// Shares the boot-ROM BRAM between host download (write) and CPU fetch (read),
// generates the CP1/CP2 phase strobes and holds the core in reset until an
// image has been loaded plus RESET_HOLD complete CP cycles.
// Optional feature: define SCV_BOOT_CTRL_PAUSE_EN to add a PAUSE input that
// freezes the phase sequencer at the end of a CP cycle.
module scv_boot_ctrl #(
  parameter int unsigned ROM_AW     = 12,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef SCV_BOOT_CTRL_PAUSE_EN
  input  logic                PAUSE,
`endif
  scv_boot_ctrl_if.slave      bus,
  input  logic [15:0]         CPU_A,
  output logic [7:0]          CPU_DB,
  output logic                CPU_RESETB,
  output logic                CP1_POSEDGE,
  output logic                CP1_NEGEDGE,
  output logic                CP2_POSEDGE,
  output logic                CP2_NEGEDGE,
  output logic                ROM_NCS,
  output logic [1:0]          STATE
);

  localparam int unsigned HOLD_W    = 8;
  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned STROBE_W  = 4;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  state_e                state_q,   state_d;
  logic [PHASE_W-1:0]    phase_q,   phase_d;
  logic [STROBE_W-1:0]   strobe_q,  strobe_d;
  logic [HOLD_W-1:0]     hold_q,    hold_d;
  logic                  wr_seen_q, wr_seen_d;
  logic                  paused_q,  paused_d;
  logic                  resetb_q,  resetb_d;

  logic                  pause_c;
  logic                  run_now_c;
  logic                  run_next_c;
  logic                  cp2_neg_c;

`ifdef SCV_BOOT_CTRL_PAUSE_EN
  assign pause_c = PAUSE;
`else
  assign pause_c = 1'b0;
`endif

  // The CP2_NEGEDGE strobe currently on the bus marks the end of a CP cycle
  assign cp2_neg_c  = strobe_q[3];
  assign run_now_c  = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign run_next_c = (state_d == ST_HOLD) || (state_d == ST_RUN);

  // Next-state, hold counter, wr_seen, phase sequencer and reset release
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wr_seen_d = wr_seen_q;
    phase_d   = '0;
    strobe_d  = '0;
    paused_d  = 1'b0;
    resetb_d  = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (bus.DL_ACTIVE) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.DL_WR) wr_seen_d = 1'b1;
        if (!bus.DL_ACTIVE) begin
          // An empty download leaves the core halted
          if (wr_seen_q || bus.DL_WR) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HOLD: begin
        if (bus.DL_ACTIVE) begin
          state_d = ST_LOAD;
        end else if (cp2_neg_c) begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.DL_ACTIVE) state_d = ST_LOAD;
      end
      default: state_d = ST_HALT;
    endcase

    // Every LOAD entry starts a fresh image
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) wr_seen_d = 1'b0;

    // Phase sequencer: one strobe per CLK, restarting at CP1_POSEDGE on HOLD entry
    if (run_next_c) begin
      if (!run_now_c) begin
        phase_d  = '0;
        strobe_d = STROBE_W'(1);
      end else if (paused_q) begin
        if (pause_c) begin
          paused_d = 1'b1;
          phase_d  = phase_q;
        end else begin
          phase_d  = '0;
          strobe_d = STROBE_W'(1);
        end
      end else if (cp2_neg_c && pause_c) begin
        // Freeze only at a CP cycle boundary so the core never sees a partial cycle
        paused_d = 1'b1;
        phase_d  = phase_q;
      end else begin
        phase_d  = phase_q + PHASE_W'(1);
        strobe_d = STROBE_W'(1) << phase_d;
      end
    end

    resetb_d = (state_d == ST_RUN);
  end

  // State, counter and strobe registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_HALT;
      phase_q   <= '0;
      strobe_q  <= '0;
      hold_q    <= '0;
      wr_seen_q <= 1'b0;
      paused_q  <= 1'b0;
      resetb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      strobe_q  <= strobe_d;
      hold_q    <= hold_d;
      wr_seen_q <= wr_seen_d;
      paused_q  <= paused_d;
      resetb_q  <= resetb_d;
    end
  end

  // BRAM port mux: host owns the port only while loading
  always_comb begin
    bus.ROM_A  = CPU_A[ROM_AW-1:0];
    bus.ROM_D  = 8'h00;
    bus.ROM_WE = 1'b0;
    if (state_q == ST_LOAD) begin
      bus.ROM_A  = bus.DL_ADDR;
      bus.ROM_D  = bus.DL_DATA;
      bus.ROM_WE = bus.DL_WR;
    end
  end

  // Address decode and read data; the core holds its address for a full CP
  // cycle, which hides the one-CLK BRAM read latency
  always_comb begin
    ROM_NCS = |CPU_A[15:ROM_AW];
    CPU_DB  = 8'hFF;
    if (!ROM_NCS && run_now_c) CPU_DB = bus.ROM_Q;
  end

  assign CPU_RESETB  = resetb_q;
  assign CP1_POSEDGE = strobe_q[0];
  assign CP1_NEGEDGE = strobe_q[1];
  assign CP2_POSEDGE = strobe_q[2];
  assign CP2_NEGEDGE = strobe_q[3];
  assign STATE       = 2'(state_q);

endmodule

// File: tb/tb_scv_boot_ctrl.sv
// Self-checking bench for scv_boot_ctrl with a behavioural 1-CLK-latency BRAM.
module tb_scv_boot_ctrl;

  localparam int unsigned ROM_AW     = 12;
  localparam int unsigned RESET_HOLD = 16;
  localparam int          DEPTH      = 1 << ROM_AW;
  localparam int          HOLD_CYC   = 4 * RESET_HOLD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_db;
  logic        cpu_resetb;
  logic        cp1p, cp1n, cp2p, cp2n;
  logic        rom_ncs;
  logic [1:0]  state;
  logic [3:0]  strb;
`ifdef SCV_BOOT_CTRL_PAUSE_EN
  logic        pause;
`endif

  scv_boot_ctrl_if #(.ROM_AW(ROM_AW)) bus ();

  logic [7:0] mem [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_strb_q [$];
  logic       exp_rb_q   [$];
  logic [1:0] exp_st_q   [$];
  logic [7:0] exp_db_q   [$];

  scv_boot_ctrl #(.ROM_AW(ROM_AW), .RESET_HOLD(RESET_HOLD)) dut (
    .CLK         (clk),
    .RESET       (rst),
`ifdef SCV_BOOT_CTRL_PAUSE_EN
    .PAUSE       (pause),
`endif
    .bus         (bus),
    .CPU_A       (cpu_a),
    .CPU_DB      (cpu_db),
    .CPU_RESETB  (cpu_resetb),
    .CP1_POSEDGE (cp1p),
    .CP1_NEGEDGE (cp1n),
    .CP2_POSEDGE (cp2p),
    .CP2_NEGEDGE (cp2n),
    .ROM_NCS     (rom_ncs),
    .STATE       (state)
  );

  assign strb = {cp2n, cp2p, cp1n, cp1p};

  always #5 clk = ~clk;

  // Behavioural single-port BRAM, registered read
  always @(posedge clk) begin
    if (bus.ROM_WE) mem[bus.ROM_A] <= bus.ROM_D;
    bus.ROM_Q <= mem[bus.ROM_A];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dl_begin();
    bus.DL_ACTIVE = 1'b1;
    bus.DL_WR     = 1'b0;
    tick();
  endtask

  task automatic dl_write(input logic [11:0] a, input logic [7:0] d);
    bus.DL_WR   = 1'b1;
    bus.DL_ADDR = a;
    bus.DL_DATA = d;
    tick();
    bus.DL_WR   = 1'b0;
  endtask

  task automatic dl_end();
    bus.DL_WR     = 1'b0;
    bus.DL_ACTIVE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else n_pass++;
    n_checks++;
    if (strb !== 4'b0000) $display("FAIL reset_strobes: got %b expected 0000", strb);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL idle_state: got %0d expected 0", state);
    else n_pass++;
    n_checks++;
    if (strb !== 4'b0000) $display("FAIL idle_strobes: got %b expected 0000", strb);
    else n_pass++;
    n_checks++;
    if (cpu_resetb !== 1'b0) $display("FAIL idle_resetb: got %b expected 0", cpu_resetb);
    else n_pass++;
    n_checks++;
    if (cpu_db !== 8'hFF) $display("FAIL idle_db: got %h expected ff", cpu_db);
    else n_pass++;
    n_checks++;
    if (bus.ROM_WE !== 1'b0) $display("FAIL idle_we: got %b expected 0", bus.ROM_WE);
    else n_pass++;
  endtask

  task automatic test_download();
    logic [3:0] es;
    logic       er;
    logic [1:0] est;
    dl_begin();
    n_checks++;
    if (state !== 2'd1) $display("FAIL dl_load_state: got %0d expected 1", state);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) dl_write(12'(a), 8'(a) ^ 8'h5A);
    dl_end();
    // Expected HOLD sequence plus the first RUN cycle
    for (int i = 0; i < HOLD_CYC + 4; i++) begin
      es = 4'b0001 << (i % 4);
      exp_strb_q.push_back(es);
      exp_rb_q.push_back(i >= HOLD_CYC);
      exp_st_q.push_back((i >= HOLD_CYC) ? 2'd3 : 2'd2);
    end
    for (int i = 0; exp_strb_q.size() > 0; i++) begin
      es  = exp_strb_q.pop_front();
      er  = exp_rb_q.pop_front();
      est = exp_st_q.pop_front();
      n_checks++;
      if (strb !== es) $display("FAIL hold_strobe[%0d]: got %b expected %b", i, strb, es);
      else n_pass++;
      n_checks++;
      if (cpu_resetb !== er) $display("FAIL hold_resetb[%0d]: got %b expected %b", i, cpu_resetb, er);
      else n_pass++;
      n_checks++;
      if (state !== est) $display("FAIL hold_state[%0d]: got %0d expected %0d", i, state, est);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_rom_read();
    int         a;
    logic [7:0] ed;
    cpu_a = 16'h0123;
    exp_db_q.push_back(8'h79);
    exp_db_q.push_back(8'h79);
    for (int k = 0; k < 2; k++) begin
      tick();
      ed = exp_db_q.pop_front();
      n_checks++;
      if (cpu_db !== ed) $display("FAIL read_0123[%0d]: got %h expected %h", k, cpu_db, ed);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(DEPTH - 1, 0);
      cpu_a = 16'(a);
      exp_db_q.push_back(8'(a) ^ 8'h5A);
      tick();
      ed = exp_db_q.pop_front();
      n_checks++;
      if (cpu_db !== ed) $display("FAIL read_rand a=%h: got %h expected %h", a, cpu_db, ed);
      else n_pass++;
    end
    cpu_a = 16'h0FFF;
    tick();
    n_checks++;
    if (cpu_db !== 8'hA5) $display("FAIL read_top: got %h expected a5", cpu_db);
    else n_pass++;
    n_checks++;
    if (rom_ncs !== 1'b0) $display("FAIL ncs_top: got %b expected 0", rom_ncs);
    else n_pass++;
    cpu_a = 16'h1000;
    #1;
    n_checks++;
    if (rom_ncs !== 1'b1) $display("FAIL ncs_1000: got %b expected 1", rom_ncs);
    else n_pass++;
    n_checks++;
    if (cpu_db !== 8'hFF) $display("FAIL db_1000: got %h expected ff", cpu_db);
    else n_pass++;
    tick();
    n_checks++;
    if (cpu_db !== 8'hFF) $display("FAIL db_1000_late: got %h expected ff", cpu_db);
    else n_pass++;
  endtask

  task automatic test_stray_write();
    cpu_a         = 16'h0000;
    bus.DL_ADDR   = 12'h000;
    bus.DL_DATA   = 8'h11;
    bus.DL_WR     = 1'b1;
    #1;
    n_checks++;
    if (bus.ROM_WE !== 1'b0) $display("FAIL stray_we: got %b expected 0", bus.ROM_WE);
    else n_pass++;
    tick();
    bus.DL_WR = 1'b0;
    tick();
    n_checks++;
    if (cpu_db !== 8'h5A) $display("FAIL stray_read: got %h expected 5a", cpu_db);
    else n_pass++;
    n_checks++;
    if (state !== 2'd3) $display("FAIL stray_state: got %0d expected 3", state);
    else n_pass++;
  endtask

  task automatic test_empty_download();
    bus.DL_ACTIVE = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd1) $display("FAIL empty_load_state: got %0d expected 1", state);
    else n_pass++;
    n_checks++;
    if (cpu_resetb !== 1'b0) $display("FAIL empty_load_resetb: got %b expected 0", cpu_resetb);
    else n_pass++;
    n_checks++;
    if (strb !== 4'b0000) $display("FAIL empty_load_strobes: got %b expected 0000", strb);
    else n_pass++;
    bus.DL_ACTIVE = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL empty_halt_state: got %0d expected 0", state);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ((strb !== 4'b0000) || (cpu_resetb !== 1'b0) || (state !== 2'd0))
        $display("FAIL empty_idle[%0d]: got strb=%b rb=%b st=%0d expected 0000/0/0",
                 i, strb, cpu_resetb, state);
      else n_pass++;
    end
    n_checks++;
    if (cpu_db !== 8'hFF) $display("FAIL empty_db: got %h expected ff", cpu_db);
    else n_pass++;
  endtask

  task automatic test_redownload();
    logic found;
    dl_begin();
    dl_write(12'h010, 8'h4A);
    dl_end();
    found = 1'b0;
    for (int i = 0; (i < HOLD_CYC + 16) && !found; i++) begin
      if (state === 2'd3) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) $display("FAIL wait_run: got state %0d expected 3 within budget", state);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; (i < 8) && !found; i++) begin
      if (cp2p === 1'b1) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) $display("FAIL wait_phase2: got strb %b expected 0100 within budget", strb);
    else n_pass++;
    bus.DL_ACTIVE = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd1) $display("FAIL redl_state: got %0d expected 1", state);
    else n_pass++;
    n_checks++;
    if (cpu_resetb !== 1'b0) $display("FAIL redl_resetb: got %b expected 0", cpu_resetb);
    else n_pass++;
    n_checks++;
    if (strb !== 4'b0000) $display("FAIL redl_strobes: got %b expected 0000", strb);
    else n_pass++;
    dl_write(12'h000, 8'hAA);
    dl_end();
    n_checks++;
    if ((state !== 2'd2) || (strb !== 4'b0001))
      $display("FAIL redl_hold: got st=%0d strb=%b expected 2/0001", state, strb);
    else n_pass++;
    for (int i = 0; i < HOLD_CYC; i++) tick();
    n_checks++;
    if ((state !== 2'd3) || (cpu_resetb !== 1'b1))
      $display("FAIL redl_run: got st=%0d rb=%b expected 3/1", state, cpu_resetb);
    else n_pass++;
    cpu_a = 16'h0000;
    exp_db_q.push_back(8'hAA);
    tick();
    n_checks++;
    if (cpu_db !== exp_db_q[0]) $display("FAIL redl_read: got %h expected %h", cpu_db, exp_db_q[0]);
    else n_pass++;
    void'(exp_db_q.pop_front());
  endtask

  task automatic test_reset_mid_load();
    dl_begin();
    for (int i = 0; i < 10; i++) dl_write(12'(12'h200 + i), 8'h33);
    bus.DL_ADDR = 12'h20A;
    bus.DL_DATA = 8'h33;
    bus.DL_WR   = 1'b1;
    rst         = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL rst_load_state: got %0d expected 0", state);
    else n_pass++;
    n_checks++;
    if (bus.ROM_WE !== 1'b0) $display("FAIL rst_load_we: got %b expected 0", bus.ROM_WE);
    else n_pass++;
    n_checks++;
    if ((strb !== 4'b0000) || (cpu_resetb !== 1'b0))
      $display("FAIL rst_load_outs: got strb=%b rb=%b expected 0000/0", strb, cpu_resetb);
    else n_pass++;
    bus.DL_WR     = 1'b0;
    bus.DL_ACTIVE = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL rst_after_state: got %0d expected 0", state);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    cpu_a         = 16'h0000;
    bus.DL_ACTIVE = 1'b0;
    bus.DL_WR     = 1'b0;
    bus.DL_ADDR   = '0;
    bus.DL_DATA   = 8'h00;
`ifdef SCV_BOOT_CTRL_PAUSE_EN
    pause         = 1'b0;
`endif
    test_reset();
    test_download();
    test_rom_read();
    test_stray_write();
    test_empty_download();
    test_redownload();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scv_boot_ctrl.md
Name: scv_boot_ctrl

Overview:
Boot/run sequencer for the uPD7800 core in the Super Cassette Vision top level.
- Owns the 4 KiB internal boot-ROM block RAM and shares its single port between the host download path (write) and CPU instruction fetch (read).
- Generates the four CP1/CP2 phase strobes that clock the core.
- Holds the core in reset until a ROM image has been loaded, then releases it after a programmable settle interval.

Parameters:
ROM_AW, 12, boot-ROM address width (ROM depth = 2**ROM_AW bytes).
RESET_HOLD, 16, number of complete CP cycles (CP2_NEGEDGE count) the CPU stays in reset after a download ends; range 1..255.

Ports:
CLK  in  1  system clock; one phase strobe per CLK when running.
RESET  in  1  synchronous, active-high reset.
DL_ACTIVE  in  1  host download in progress.
DL_WR  in  1  download byte strobe, one CLK wide.
DL_ADDR  in  ROM_AW  download byte address.
DL_DATA  in  8  download byte.
CPU_A  in  16  core address bus.
CPU_DB  out  8  data to core DB_I.
CPU_RESETB  out  1  core reset, active low.
CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE  out  1 each  phase strobes to core.
ROM_A  out  ROM_AW  BRAM address.
ROM_D  out  8  BRAM write data.
ROM_WE  out  1  BRAM write enable.
ROM_Q  in  8  BRAM read data, 1-CLK registered latency.
ROM_NCS  out  1  boot-ROM chip select, active low.
STATE  out  2  debug: 0=HALT, 1=LOAD, 2=HOLD, 3=RUN.

Behaviour:
- FSM states: HALT, LOAD, HOLD, RUN. All state, counters and strobes are registered; transitions take effect on the next CLK.
- RESET=1: state HALT, phase counter 0, all strobes 0, CPU_RESETB 0, hold counter 0, wr_seen 0. RESET wins over every other input, including mid-download.
- HALT: strobes 0, CPU_RESETB 0. Moves to LOAD when DL_ACTIVE=1.
- LOAD:
  - Clears wr_seen on entry.
  - Sets wr_seen on each DL_WR.
  - When DL_ACTIVE falls: go to HOLD with hold counter = RESET_HOLD if wr_seen=1; otherwise go to HALT (empty download leaves the core halted).
- HOLD:
  - Phase sequencer runs; CPU_RESETB 0.
  - Hold counter decrements on each CP2_NEGEDGE.
  - The CP2_NEGEDGE that takes it from 1 to 0 moves the FSM to RUN; CPU_RESETB goes 1 on the following CLK.
- RUN: phase sequencer runs; CPU_RESETB 1.
- DL_ACTIVE=1 in HOLD or RUN: next state LOAD. On the same next edge CPU_RESETB goes 0 and strobes stop.
- Phase sequencer:
  - 2-bit counter, active only in HOLD/RUN; forced to 0 in HALT/LOAD.
  - Count 0,1,2,3 drives CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE respectively, exactly one strobe high per CLK.
  - After entering HOLD, the first strobe is CP1_POSEDGE; the counter wraps 3->0.
- ROM port mux:
  - In LOAD: ROM_A=DL_ADDR, ROM_D=DL_DATA, ROM_WE=DL_WR, combinational pass-through.
  - Otherwise: ROM_A=CPU_A[ROM_AW-1:0], ROM_WE=0, ROM_D=0.
  - A DL_WR outside LOAD is ignored.
- Decode:
  - ROM_NCS = |CPU_A[15:ROM_AW].
  - CPU_DB = ROM_Q when ROM_NCS=0 and state is HOLD/RUN; otherwise 8'hFF.
  - The 1-CLK BRAM latency is hidden because the core holds the address for 4 CLKs.
- Re-download over a running image: the new image fully replaces the old one; wr_seen is cleared on every LOAD entry.

Optional Feature:
Macro SCV_BOOT_CTRL_PAUSE_EN.
- Defined:
  - Adds input PAUSE (1 bit).
  - In HOLD/RUN, PAUSE=1 freezes the phase counter after the next CP2_NEGEDGE. Strobes are 0 while frozen; the hold counter is frozen.
  - PAUSE=0 resumes with CP1_POSEDGE on the next CLK.
  - PAUSE is ignored in HALT/LOAD; DL_ACTIVE still overrides a pause.
  - STATE is unchanged by a pause.
- Undefined: no PAUSE port; the sequencer runs freely.

Test Plan:
1. Reset, then idle 20 CLK -> STATE=0, all strobes 0, CPU_RESETB=0, CPU_DB=8'hFF.
2. Download 4096 bytes (mem[a]=a[7:0]^8'h5A), drop DL_ACTIVE ->
   - STATE=2, first strobe CP1_POSEDGE, strobes cycle in order one per CLK.
   - CPU_RESETB rises exactly 1 CLK after the 16th CP2_NEGEDGE.
3. RUN, CPU_A=16'h0123 -> CPU_DB=8'h79 from the 2nd CLK on. CPU_A=16'h1000 -> ROM_NCS=1, CPU_DB=8'hFF.
4. DL_ACTIVE pulse with zero DL_WR -> LOAD then HALT. CPU_RESETB stays 0 and no strobes appear.
5. Assert DL_ACTIVE during RUN at phase 2 -> next CLK: STATE=1, CPU_RESETB=0, strobes 0. Re-download byte 0=8'hAA -> after HOLD, CPU_A=0 reads 8'hAA.
6. RESET asserted mid-LOAD after 10 writes -> STATE=0 next CLK, ROM_WE=0. (PAUSE_EN build: PAUSE at phase 1 -> CP1_NEGEDGE and CP2 strobes finish, then freeze; release gives CP1_POSEDGE.)
